memsplit_master: RTL and testbench

- Single-outstanding bus initiator for the 32-bit split request/response bus: the master end of the protocol that CSR and test-memory responders implement.
- Accepts one command at a time on a valid/ready command port and drives `req`/`we`/`addr`/`be`/`wdata` until the slave acks.
- For reads, waits for `resp` and captures `rdata`.
- Returns a one-cycle response pulse carrying read data and a timeout-error flag.
- Used by on-chip engines (DMA, test sequencers) that need bus access in parallel with the UART debug master.

---
 rtl/memsplit_master.sv | 93 +++++++++
 tb/tb_memsplit_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/memsplit_master.sv
// memsplit_master: single-outstanding initiator for the split request/response bus
// Ports: clk_i/rst_i (sync active-high); cmd_* valid/ready command in;
// rsp_* one-cycle completion pulse with read data and timeout flag; bus_* request out, ack/resp/rdata in.
module memsplit_master #(
  parameter int BUS_TIMEOUT = 1024,
  localparam int CNT_W = $clog2(BUS_TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_addr_bi,
  input  logic [3:0]  cmd_be_bi,
  input  logic [31:0] cmd_wdata_bi,
  output logic        rsp_valid_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_rdata_bo,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_bo,
  output logic [3:0]  bus_be_bo,
  output logic [31:0] bus_wdata_bo,
  input  logic        bus_ack_i,
  input  logic        bus_resp_i,
  input  logic [31:0] bus_rdata_bi
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic req_n, we_n, vld_n, err_n, rd_hit, done, tout;
  logic [31:0] addr_n, wdata_n, rdata_n;
  logic [3:0] be_n;
  assign cmd_ready_o = state == IDLE;
  always_comb begin
    rd_hit = (state == REQ && bus_ack_i && !bus_we_o && bus_resp_i) || (state == RESP && bus_resp_i);
    done = rd_hit || (state == REQ && bus_ack_i && bus_we_o);
    // completing on the threshold cycle wins over the timeout
    tout = state != IDLE && cnt == CNT_W'(BUS_TIMEOUT - 1) && !done;
    state_n = state;
    cnt_n = state == IDLE ? '0 : cnt + CNT_W'(1);
    req_n = bus_req_o;
    we_n = bus_we_o;
    addr_n = bus_addr_bo;
    be_n = bus_be_bo;
    wdata_n = bus_wdata_bo;
    vld_n = 1'b0;
    err_n = rsp_err_o;
    rdata_n = rsp_rdata_bo;
    if (state == IDLE && cmd_valid_i) begin
      state_n = REQ;
      req_n = 1'b1;
      we_n = cmd_we_i;
      addr_n = cmd_addr_bi;
      be_n = cmd_be_bi;
      wdata_n = cmd_wdata_bi;
    end else if (done || tout) begin
      state_n = IDLE;
      req_n = 1'b0;
      vld_n = 1'b1;
      err_n = tout;
      rdata_n = rd_hit ? bus_rdata_bi : '0;
    end else if (state == REQ && bus_ack_i) begin
      state_n = RESP;
      req_n = 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      bus_req_o <= 1'b0;
      bus_we_o <= 1'b0;
      bus_addr_bo <= '0;
      bus_be_bo <= '0;
      bus_wdata_bo <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o <= 1'b0;
      rsp_rdata_bo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bus_req_o <= req_n;
      bus_we_o <= we_n;
      bus_addr_bo <= addr_n;
      bus_be_bo <= be_n;
      bus_wdata_bo <= wdata_n;
      rsp_valid_o <= vld_n;
      rsp_err_o <= err_n;
      rsp_rdata_bo <= rdata_n;
    end
  end
endmodule

// File: tb/tb_memsplit_master.sv
// tb_memsplit_master: table-driven and scoreboarded bench for memsplit_master with BUS_TIMEOUT=8
module tb_memsplit_master;
  logic clk_i = 1'b0, rst_i = 1'b1, cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
  logic [31:0] cmd_addr_bi = '0, cmd_wdata_bi = '0, bus_rdata_bi = '0;
  logic [3:0] cmd_be_bi = '0;
  logic bus_ack_i = 1'b0, bus_resp_i = 1'b0;
  logic cmd_ready_o, rsp_valid_o, rsp_err_o, bus_req_o, bus_we_o;
  logic [31:0] rsp_rdata_bo, bus_addr_bo, bus_wdata_bo;
  logic [3:0] bus_be_bo;
  memsplit_master #(.BUS_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_bi(cmd_addr_bi), .cmd_be_bi(cmd_be_bi), .cmd_wdata_bi(cmd_wdata_bi),
    .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_bo(rsp_rdata_bo),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_bo(bus_addr_bo),
    .bus_be_bo(bus_be_bo), .bus_wdata_bo(bus_wdata_bo),
    .bus_ack_i(bus_ack_i), .bus_resp_i(bus_resp_i), .bus_rdata_bi(bus_rdata_bi)
  );
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;
    int ack_c; int resp_c; logic [31:0] rdata;
    logic exp_err; logic [31:0] exp_rdata; int exp_req; int exp_lat;
  } vec_t;
  typedef struct { logic err; logic [31:0] rdata; int req; int lat; } exp_t;
  exp_t sb[$];
  vec_t tbl[11];
  vec_t v;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // ack/resp are driven by cycle index c, where c=0 is the first cycle with bus_req_o high
  task automatic run_txn(input vec_t t);
    int w = 0, nreq = 0;
    bit got = 0;
    exp_t e;
    while (!cmd_ready_o && w < 20) begin @(negedge clk_i); w++; end
    chk("ready_before_cmd", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = t.we; cmd_addr_bi = t.addr; cmd_be_bi = t.be; cmd_wdata_bi = t.wdata;
    bus_rdata_bi = t.rdata;
    sb.push_back('{t.exp_err, t.exp_rdata, t.exp_req, t.exp_lat});
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid_o) begin
        bus_ack_i = 1'b0; bus_resp_i = 1'b0;
        chk("rsp_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rsp_req_low", 32'(bus_req_o), 32'd0);
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got response with empty scoreboard");
        end else begin
          e = sb.pop_front();
          chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
          chk("rsp_rdata", rsp_rdata_bo, e.rdata);
          chk("rsp_latency", 32'(c), 32'(e.lat));
          chk("req_cycles", 32'(nreq), 32'(e.req));
        end
        got = 1;
        break;
      end
      if (bus_req_o) begin
        nreq++;
        chk("req_ready_low", 32'(cmd_ready_o), 32'd0);
        chk("bus_we", 32'(bus_we_o), 32'(t.we));
        chk("bus_addr", bus_addr_bo, t.addr);
        chk("bus_be", 32'(bus_be_bo), 32'(t.be));
        chk("bus_wdata", bus_wdata_bo, t.wdata);
      end
      bus_ack_i = c == t.ack_c;
      bus_resp_i = !t.we && c == t.resp_c;
      @(negedge clk_i);
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: no rsp_valid_o within 40 cycles for addr %h", t.addr);
      bus_ack_i = 1'b0; bus_resp_i = 1'b0;
    end
  endtask
  initial begin
    tbl[0]  = '{1'b1, 32'h00000000, 4'hF, 32'h0000A5A5, 0, 99, 32'h0,        1'b0, 32'h0,        1, 1};
    tbl[1]  = '{1'b0, 32'h80000004, 4'hF, 32'h0,        0, 1,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1, 2};
    tbl[2]  = '{1'b1, 32'h00000010, 4'h3, 32'hCAFE0001, 5, 99, 32'h0,        1'b0, 32'h0,        6, 6};
    tbl[3]  = '{1'b0, 32'h00000020, 4'hF, 32'h0,        2, 2,  32'h12345678, 1'b0, 32'h12345678, 3, 3};
    tbl[4]  = '{1'b1, 32'h00000030, 4'h1, 32'h00000011, 99, 99, 32'h0,       1'b1, 32'h0,        8, 8};
    tbl[5]  = '{1'b0, 32'h00000040, 4'hF, 32'h0,        0, 99, 32'hAAAAAAAA, 1'b1, 32'h0,        1, 8};
    tbl[6]  = '{1'b1, 32'h00000050, 4'hC, 32'h0F0F0F0F, 7, 99, 32'h0,        1'b0, 32'h0,        8, 8};
    tbl[7]  = '{1'b0, 32'h00000060, 4'hF, 32'h0,        6, 7,  32'h0BADF00D, 1'b0, 32'h0BADF00D, 7, 8};
    tbl[8]  = '{1'b0, 32'h00000070, 4'hF, 32'h0,        7, 99, 32'h13579BDF, 1'b1, 32'h0,        8, 8};
    tbl[9]  = '{1'b0, 32'h00000074, 4'hF, 32'h0,        7, 7,  32'h55AA55AA, 1'b0, 32'h55AA55AA, 8, 8};
    tbl[10] = '{1'b0, 32'h00000080, 4'hF, 32'h0,        3, 1,  32'hFFFFFFFF, 1'b1, 32'h0,        4, 8};
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_req", 32'(bus_req_o), 32'd0);
    chk("rst_we", 32'(bus_we_o), 32'd0);
    chk("rst_addr", bus_addr_bo, 32'd0);
    chk("rst_be", 32'(bus_be_bo), 32'd0);
    chk("rst_wdata", bus_wdata_bo, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata_bo, 32'd0);
    bus_ack_i = 1'b1; bus_resp_i = 1'b1; bus_rdata_bi = 32'h99999999;
    repeat (2) @(negedge clk_i);
    chk("idle_stray_req", 32'(bus_req_o), 32'd0);
    chk("idle_stray_rsp", 32'(rsp_valid_o), 32'd0);
    chk("idle_stray_ready", 32'(cmd_ready_o), 32'd1);
    bus_ack_i = 1'b0; bus_resp_i = 1'b0;
    for (int i = 0; i < 11; i++) run_txn(tbl[i]);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_bi = 32'h90; cmd_be_bi = 4'hF;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("rstresp_req", 32'(bus_req_o), 32'd1);
    bus_ack_i = 1'b1;
    @(negedge clk_i);
    bus_ack_i = 1'b0;
    chk("rstresp_in_resp", 32'({bus_req_o, cmd_ready_o}), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rstresp_req_low", 32'(bus_req_o), 32'd0);
    chk("rstresp_no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("rstresp_ready", 32'(cmd_ready_o), 32'd1);
    bus_resp_i = 1'b1; bus_rdata_bi = 32'h77777777;
    @(negedge clk_i);
    bus_resp_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_resp_ignored", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
    end
    chk("late_resp_rdata", rsp_rdata_bo, 32'd0);
    chk("late_resp_err", 32'(rsp_err_o), 32'd0);
    for (int i = 0; i < 16; i++) begin
      v.we = i % 2 == 0;
      v.addr = 32'h1000 + 32'(i * 4);
      v.be = 4'hF;
      v.wdata = $urandom;
      v.ack_c = $urandom_range(0, 3);
      v.resp_c = v.ack_c + $urandom_range(0, 2);
      v.rdata = $urandom;
      v.exp_err = 1'b0;
      v.exp_rdata = v.we ? 32'h0 : v.rdata;
      v.exp_req = v.ack_c + 1;
      v.exp_lat = (v.we ? v.ack_c : v.resp_c) + 1;
      run_txn(v);
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
